staggered_add_ctrl: RTL

Sequencing controller for the staggered adder. It performs a WIDTH-bit addition by time-multiplexing one 4-bit carry-lookahead slice over WIDTH/4 cycles, least-significant nibble first, and registers the slice carry-out between cycles. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake. The block sits between the operand source and the result consumer, and owns the only slice instance.

---
 rtl/staggered_add_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/staggered_add_ctrl.sv
// Staggered adder controller: a WIDTH-bit add done in WIDTH/4 cycles through one 4-bit CLA slice,
// least-significant nibble first, with valid/ready handshakes on both operand and result sides.
module staggered_add_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("staggered_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end
  if (SLICE != 4) begin : g_bad_slice
    $error("staggered_add_ctrl: SLICE is fixed at 4");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              hs_in;
  logic              last_slice;
  logic [CntW+1:0]   nib_base;
  logic [3:0]        slice_a, slice_b;
  logic [3:0]        p, g, s;
  logic [4:0]        c;

  // Slice operands come only from the operand registers, never from the a/b ports.
  assign nib_base   = {cnt_q, 2'b00};
  assign slice_a    = a_q[nib_base +: 4];
  assign slice_b    = b_q[nib_base +: 4];
  assign last_slice = (cnt_q == CntW'(NSLICE - 1));

  // 4-bit carry-lookahead slice with full lookahead carries.
  assign p    = slice_a ^ slice_b;
  assign g    = slice_a & slice_b;
  assign c[0] = c_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];

  assign in_ready = (state_q == StIdle) & ~rst;
  assign hs_in    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (hs_in) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[nib_base +: 4] = s;
        c_d                  = c[4];
        if (last_slice) begin
          // s[3] of the top slice is the sum MSB.
          cout_d  = c[4];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s[3] != a_q[WIDTH-1]);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  cnt_in_range_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntW'(NSLICE - 1));

endmodule
